lattice_stream_sweep: RTL and testbench

// Sweep sequencer for the 9-plane LBM distribution BRAMs (pull-streaming side).

---
 rtl/lattice_stream_sweep.sv | 151 +++++++++++++++
 tb/tb_lattice_stream_sweep.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lattice_stream_sweep.sv
// Raster sweep sequencer for the 9-plane LBM distribution BRAMs: per-cell pull-streaming
// read addresses (periodic wrap) and the cell's own write address LATENCY cycles later.
module lattice_stream_sweep #(
  parameter int HPIXELS = 205,
  parameter int VPIXELS = 154,
  parameter int LATENCY = 3,
  localparam int HOR_SIZE  = $clog2(HPIXELS),
  localparam int VERT_SIZE = $clog2(VPIXELS),
  localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS)
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic                            stall_in,
  output logic                            rd_valid_out,
  output logic [8:0][BRAM_SIZE-1:0]       rd_addr_out,
  output logic [HOR_SIZE-1:0]             hor_out,
  output logic [VERT_SIZE-1:0]            vert_out,
  output logic                            wr_valid_out,
  output logic [BRAM_SIZE-1:0]            wr_addr_out,
  output logic                            busy_out,
  output logic                            done_out
);

  localparam logic [HOR_SIZE-1:0]  X_LAST     = HOR_SIZE'(HPIXELS - 1);
  localparam logic [VERT_SIZE-1:0] Y_LAST     = VERT_SIZE'(VPIXELS - 1);
  localparam logic [HOR_SIZE-1:0]  X_ONE      = HOR_SIZE'(1);
  localparam logic [VERT_SIZE-1:0] Y_ONE      = VERT_SIZE'(1);
  localparam logic [BRAM_SIZE-1:0] ROW_STRIDE = BRAM_SIZE'(HPIXELS);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [HOR_SIZE-1:0]    x_reg;
  logic [VERT_SIZE-1:0]   y_reg;
  logic [HOR_SIZE-1:0]    x_dec, x_inc;
  logic [VERT_SIZE-1:0]   y_dec, y_inc;
  logic                   issue, last_cell, pipe_pending, done_next;
  logic [HOR_SIZE-1:0]    src_x [9];
  logic [VERT_SIZE-1:0]   src_y [9];
  logic [BRAM_SIZE-1:0]   plane_addr [9];
  logic [LATENCY-1:0]     wr_vld_pipe;
  logic [BRAM_SIZE-1:0]   wr_addr_pipe [LATENCY];

  function automatic logic [BRAM_SIZE-1:0] cell_addr(input logic [HOR_SIZE-1:0]  cx,
                                                     input logic [VERT_SIZE-1:0] cy);
    return BRAM_SIZE'(cy) * ROW_STRIDE + BRAM_SIZE'(cx);
  endfunction

  // Neighbour coordinates wrap by comparison, so non-power-of-two sizes stay in range
  assign x_dec = (x_reg == '0)     ? X_LAST : x_reg - X_ONE;
  assign x_inc = (x_reg == X_LAST) ? '0     : x_reg + X_ONE;
  assign y_dec = (y_reg == '0)     ? Y_LAST : y_reg - Y_ONE;
  assign y_inc = (y_reg == Y_LAST) ? '0     : y_reg + Y_ONE;
  assign last_cell = (x_reg == X_LAST) && (y_reg == Y_LAST);

  // Each plane pulls from the neighbour opposite to its streaming direction
  assign src_x[0] = x_reg;  assign src_y[0] = y_reg;
  assign src_x[1] = x_reg;  assign src_y[1] = y_inc;
  assign src_x[2] = x_dec;  assign src_y[2] = y_inc;
  assign src_x[3] = x_dec;  assign src_y[3] = y_reg;
  assign src_x[4] = x_dec;  assign src_y[4] = y_dec;
  assign src_x[5] = x_reg;  assign src_y[5] = y_dec;
  assign src_x[6] = x_inc;  assign src_y[6] = y_dec;
  assign src_x[7] = x_inc;  assign src_y[7] = y_reg;
  assign src_x[8] = x_inc;  assign src_y[8] = y_inc;

  for (genvar gi = 0; gi < 9; gi++) begin : g_plane
    assign plane_addr[gi] = cell_addr(src_x[gi], src_y[gi]);
  end

  // Anything still in flight except the stage currently presented as the write
  always_comb begin
    pipe_pending = rd_valid_out;
    for (int i = 0; i < LATENCY - 1; i++) begin
      pipe_pending = pipe_pending | wr_vld_pipe[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_in && !done_out) begin
          issue      = !stall_in;
          state_next = (!stall_in && last_cell) ? DRAIN : SWEEP;
        end
      end
      SWEEP: begin
        issue = !stall_in;
        if (!stall_in && last_cell) state_next = DRAIN;
      end
      DRAIN: begin
        if (!pipe_pending) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_reg        <= '0;
      y_reg        <= '0;
      rd_valid_out <= 1'b0;
      rd_addr_out  <= '0;
      hor_out      <= '0;
      vert_out     <= '0;
      done_out     <= 1'b0;
    end else begin
      rd_valid_out <= issue;
      done_out     <= done_next;
      if (issue) begin
        hor_out  <= x_reg;
        vert_out <= y_reg;
        for (int p = 0; p < 9; p++) rd_addr_out[p] <= plane_addr[p];
        x_reg <= x_inc;
        if (x_reg == X_LAST) y_reg <= y_inc;
      end
    end
  end

  // Free-running write pipe: stalls only affect what enters it, so bubbles are preserved
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_vld_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) wr_addr_pipe[i] <= '0;
    end else begin
      wr_vld_pipe[0]  <= rd_valid_out;
      wr_addr_pipe[0] <= rd_addr_out[0];
      for (int i = 1; i < LATENCY; i++) begin
        wr_vld_pipe[i]  <= wr_vld_pipe[i-1];
        wr_addr_pipe[i] <= wr_addr_pipe[i-1];
      end
    end
  end

  assign wr_valid_out = wr_vld_pipe[LATENCY-1];
  assign wr_addr_out  = wr_addr_pipe[LATENCY-1];
  assign busy_out     = (state_reg != IDLE);

endmodule

// File: tb/tb_lattice_stream_sweep.sv
// Scoreboard bench for lattice_stream_sweep: expected cells queued at start, monitor
// compares every read/write pulse against a wrap-arithmetic reference model.
module tb_lattice_stream_sweep;

  localparam int H  = 205;
  localparam int V  = 154;
  localparam int L  = 3;
  localparam int N  = H * V;
  localparam int BS = $clog2(N);
  localparam int HS = $clog2(H);
  localparam int VS = $clog2(V);

  logic                 clk_in = 1'b0;
  logic                 rst_n_in = 1'b0;
  logic                 start_in = 1'b0;
  logic                 stall_in = 1'b0;
  logic                 rd_valid_out;
  logic [8:0][BS-1:0]   rd_addr_out;
  logic [HS-1:0]        hor_out;
  logic [VS-1:0]        vert_out;
  logic                 wr_valid_out;
  logic [BS-1:0]        wr_addr_out;
  logic                 busy_out;
  logic                 done_out;

  int tests = 0;
  int fails = 0;
  int rd_total = 0;
  int wr_total = 0;
  int done_total = 0;
  int exp_rd[$];
  int exp_wr[$];

  always #5 clk_in = ~clk_in;

  lattice_stream_sweep #(.HPIXELS(H), .VPIXELS(V), .LATENCY(L)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start_in),
    .stall_in     (stall_in),
    .rd_valid_out (rd_valid_out),
    .rd_addr_out  (rd_addr_out),
    .hor_out      (hor_out),
    .vert_out     (vert_out),
    .wr_valid_out (wr_valid_out),
    .wr_addr_out  (wr_addr_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  task automatic fail_line(input string msg);
    fails++;
    $display("FAIL %s", msg);
    if (fails >= 100) begin
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) fail_line($sformatf("%s: got %0d, expected %0d", name, act, exp));
  endtask

  // Reference: cell k in raster order; plane p reads the cell one step against its direction
  function automatic int model_addr(input int k, input int p);
    int x, y, dx, dy;
    x = k % H;
    y = k / H;
    case (p)
      0: begin dx =  0; dy =  0; end
      1: begin dx =  0; dy =  1; end
      2: begin dx = -1; dy =  1; end
      3: begin dx = -1; dy =  0; end
      4: begin dx = -1; dy = -1; end
      5: begin dx =  0; dy = -1; end
      6: begin dx =  1; dy = -1; end
      7: begin dx =  1; dy =  0; end
      default: begin dx = 1; dy = 1; end
    endcase
    return ((y + dy + V) % V) * H + ((x + dx + H) % H);
  endfunction

  task automatic push_sweep();
    for (int k = 0; k < N; k++) begin
      exp_rd.push_back(k);
      exp_wr.push_back(k);
    end
  endtask

  // Monitor
  logic [2:0] rd_hist;
  int         hist_cnt;
  logic       prev_wr, prev_done;
  int         mk, bad_p;

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      exp_rd.delete();
      exp_wr.delete();
      rd_hist = '0; hist_cnt = 0; prev_wr = 1'b0; prev_done = 1'b0;
    end else begin
      if (rd_valid_out) begin
        rd_total++;
        if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          mk = exp_rd.pop_front();
          bad_p = -1;
          for (int p = 0; p < 9; p++)
            if (int'(rd_addr_out[p]) != model_addr(mk, p)) bad_p = p;
          tests++;
          if (int'(hor_out) != mk % H || int'(vert_out) != mk / H)
            fail_line($sformatf("rd_cell_xy: got (%0d,%0d), expected (%0d,%0d)",
                                hor_out, vert_out, mk % H, mk / H));
          else if (bad_p >= 0)
            fail_line($sformatf("rd_cell_addr (%0d,%0d) plane %0d: got %0d, expected %0d",
                                mk % H, mk / H, bad_p, rd_addr_out[bad_p], model_addr(mk, bad_p)));
        end
        if (hor_out == 0 && vert_out == 0) begin
          check("spec_c00_p8", int'(rd_addr_out[8]), 206);
          check("spec_c00_p7", int'(rd_addr_out[7]), 1);
          check("spec_c00_p6", int'(rd_addr_out[6]), 31366);
          check("spec_c00_p5", int'(rd_addr_out[5]), 31365);
          check("spec_c00_p4", int'(rd_addr_out[4]), 31569);
          check("spec_c00_p3", int'(rd_addr_out[3]), 204);
          check("spec_c00_p2", int'(rd_addr_out[2]), 409);
          check("spec_c00_p1", int'(rd_addr_out[1]), 205);
          check("spec_c00_p0", int'(rd_addr_out[0]), 0);
        end
        if (hor_out == 204 && vert_out == 153) begin
          check("spec_last_p0", int'(rd_addr_out[0]), 31569);
          check("spec_last_p3", int'(rd_addr_out[3]), 31568);
          check("spec_last_p7", int'(rd_addr_out[7]), 31365);
          check("spec_last_p1", int'(rd_addr_out[1]), 204);
          check("spec_last_p8", int'(rd_addr_out[8]), 0);
        end
        if (hor_out == 100 && vert_out == 50) begin
          check("spec_mid_p0", int'(rd_addr_out[0]), 10350);
          check("spec_mid_p1", int'(rd_addr_out[1]), 10555);
          check("spec_mid_p5", int'(rd_addr_out[5]), 10145);
          check("spec_mid_p2", int'(rd_addr_out[2]), 10554);
          check("spec_mid_p6", int'(rd_addr_out[6]), 10146);
        end
      end
      if (wr_valid_out) begin
        wr_total++;
        if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
        else check("wr_addr", int'(wr_addr_out), exp_wr.pop_front());
      end
      if (hist_cnt >= 3 && (wr_valid_out || rd_hist[2]))
        check("wr_valid_delay", int'(wr_valid_out), int'(rd_hist[2]));
      if (rd_valid_out || wr_valid_out) check("busy_while_active", int'(busy_out), 1);
      if (done_out) begin
        done_total++;
        check("done_after_last_wr", int'(prev_wr), 1);
        check("done_one_cycle", int'(prev_done), 0);
        check("busy_at_done", int'(busy_out), 0);
        check("done_rd_left", exp_rd.size(), 0);
        check("done_wr_left", exp_wr.size(), 0);
      end
      rd_hist   = {rd_hist[1:0], rd_valid_out};
      hist_cnt  = (hist_cnt < 3) ? hist_cnt + 1 : hist_cnt;
      prev_wr   = wr_valid_out;
      prev_done = done_out;
    end
  end

  // Stimulus
  initial begin
    int  base_rd, base_wr, base_done;
    bit  seen, drain_poked;

    repeat (3) @(posedge clk_in);
    #1;
    check("rst_rd_valid", int'(rd_valid_out), 0);
    check("rst_wr_valid", int'(wr_valid_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_done", int'(done_out), 0);
    check("rst_rd_addr_or", int'(|rd_addr_out), 0);
    #1 rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("idle_rd_valid", int'(rd_valid_out), 0);
    check("idle_busy", int'(busy_out), 0);

    // Sweep A: no stalls, start pokes in SWEEP, DRAIN and on the done cycle
    push_sweep();
    base_rd = rd_total; base_wr = wr_total; base_done = done_total;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check("first_rd_valid", int'(rd_valid_out), 1);
    check("first_hor", int'(hor_out), 0);
    check("first_vert", int'(vert_out), 0);
    check("first_busy", int'(busy_out), 1);
    repeat (3) @(posedge clk_in);
    #1;
    check("first_wr_valid", int'(wr_valid_out), 1);
    check("first_wr_addr", int'(wr_addr_out), 0);
    seen = 1'b0; drain_poked = 1'b0;
    for (int cyc = 0; cyc < N + 100 && !seen; cyc++) begin
      @(posedge clk_in); #1;
      start_in = 1'b0;
      if (done_out) begin
        seen = 1'b1;
        start_in = 1'b1;
      end else if (cyc == 500) begin
        start_in = 1'b1;
      end else if (!drain_poked && busy_out && rd_total - base_rd == N) begin
        drain_poked = 1'b1;
        start_in = 1'b1;
      end
    end
    check("sweepA_done_seen", int'(seen), 1);
    check("sweepA_drain_poked", int'(drain_poked), 1);
    @(posedge clk_in); #1;
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post_done_no_rd", int'(rd_valid_out), 0);
      check("post_done_idle", int'(busy_out), 0);
      @(posedge clk_in); #1;
    end
    check("sweepA_rd_count", rd_total - base_rd, N);
    check("sweepA_wr_count", wr_total - base_wr, N);
    check("sweepA_done_count", done_total - base_done, 1);

    // Sweep B: random stalls, abandoned by reset around cell 1000
    push_sweep();
    base_rd = rd_total; base_done = done_total;
    stall_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check("restart_rd_valid", int'(rd_valid_out), 1);
    check("restart_hor", int'(hor_out), 0);
    check("restart_vert", int'(vert_out), 0);
    for (int cyc = 0; cyc < 5000 && rd_total - base_rd < 1000; cyc++) begin
      @(posedge clk_in); #1;
      stall_in = ($urandom_range(0, 99) < 30);
      start_in = (cyc == 200);
    end
    check("sweepB_reached_1000", int'(rd_total - base_rd >= 1000), 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("abort_rd_valid", int'(rd_valid_out), 0);
    check("abort_wr_valid", int'(wr_valid_out), 0);
    check("abort_busy", int'(busy_out), 0);
    check("abort_done", int'(done_out), 0);
    check("abort_hor", int'(hor_out), 0);
    check("abort_vert", int'(vert_out), 0);
    check("abort_rd_addr_or", int'(|rd_addr_out), 0);
    check("abort_wr_addr", int'(wr_addr_out), 0);
    stall_in = 1'b0; start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #2 rst_n_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    check("abort_no_done", done_total - base_done, 0);
    check("abort_stays_idle", int'(busy_out), 0);
    check("abort_no_rd", int'(rd_valid_out), 0);

    // Sweep C: full sweep with ~30% random stalls after the abort
    push_sweep();
    base_rd = rd_total; base_wr = wr_total; base_done = done_total;
    stall_in = ($urandom_range(0, 99) < 30);
    start_in = 1'b1;
    seen = 1'b0; drain_poked = 1'b0;
    for (int cyc = 0; cyc < 60000 && !seen; cyc++) begin
      @(posedge clk_in); #1;
      stall_in = ($urandom_range(0, 99) < 30);
      start_in = 1'b0;
      if (done_out) seen = 1'b1;
      else if (cyc == 3000) start_in = 1'b1;
      else if (!drain_poked && busy_out && rd_total - base_rd == N) begin
        drain_poked = 1'b1;
        start_in = 1'b1;
      end
    end
    stall_in = 1'b0; start_in = 1'b0;
    check("sweepC_done_seen", int'(seen), 1);
    repeat (3) @(posedge clk_in);
    #1;
    check("sweepC_rd_count", rd_total - base_rd, N);
    check("sweepC_wr_count", wr_total - base_wr, N);
    check("sweepC_done_count", done_total - base_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
